// File: rtl/alu_seq.sv
// Sequential ALU with registered result and SZCV flags, valid/ready on both sides.
// Arithmetic and logic ops finish in one cycle; shifts step one bit per cycle.
//
//  state | meaning
//  IDLE  | no result held, ready for a request
//  SHIFT | iterative shift in progress, cnt bits remaining
//  HOLD  | result presented on out with out_valid, waiting for out_ready
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctl,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       szcv
);
    localparam int SHW = $clog2(WIDTH);
    localparam int M   = WIDTH - 1;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_CMP = 4'd5;
    localparam logic [3:0] OP_MOV = 4'd6;
    localparam logic [3:0] OP_ADC = 4'd7;
    localparam logic [3:0] OP_SBC = 4'd8;
    localparam logic [3:0] OP_SLL = 4'd9;
    localparam logic [3:0] OP_SRL = 4'd10;
    localparam logic [3:0] OP_SRA = 4'd11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] out_nxt;
    logic [3:0]       szcv_nxt;
    logic             out_valid_nxt;
    logic [WIDTH-1:0] work, work_nxt;
    logic [SHW-1:0]   cnt, cnt_nxt;
    logic [3:0]       sh_op, sh_op_nxt;

    logic             accept;
    logic             is_shift;
    logic [SHW-1:0]   amt;
    logic             add_cin;
    logic             sub_bin;
    logic [WIDTH:0]   add_ext;
    logic [WIDTH:0]   sub_ext;
    logic [WIDTH-1:0] alu_out;
    logic [WIDTH-1:0] flag_r;
    logic             alu_c;
    logic             alu_v;
    logic             alu_keep;
    logic [3:0]       alu_szcv;
    logic [WIDTH-1:0] step_r;
    logic             step_c;

    assign amt      = in_b[SHW-1:0];
    assign is_shift = (alu_ctl == OP_SLL) || (alu_ctl == OP_SRL) || (alu_ctl == OP_SRA);
    assign in_ready = (state == IDLE) || ((state == HOLD) && out_ready);
    assign accept   = in_valid && in_ready;

    // szcv already holds the previous op's flags at the accept edge, so chains work back-to-back.
    assign add_cin = (alu_ctl == OP_ADC) && szcv[1];
    assign sub_bin = (alu_ctl == OP_SBC) && szcv[1];
    assign add_ext = {1'b0, in_a} + {1'b0, in_b} + {{WIDTH{1'b0}}, add_cin};
    assign sub_ext = {1'b0, in_a} - {1'b0, in_b} - {{WIDTH{1'b0}}, sub_bin};

    always_comb begin
        alu_out  = '0;
        flag_r   = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        alu_keep = 1'b0;
        case (alu_ctl)
            OP_ADD, OP_ADC: begin
                flag_r  = add_ext[M:0];
                alu_out = add_ext[M:0];
                alu_c   = add_ext[WIDTH];
                alu_v   = (in_a[M] == in_b[M]) && (add_ext[M] != in_a[M]);
            end
            OP_SUB, OP_SBC, OP_CMP: begin
                flag_r  = sub_ext[M:0];
                alu_out = (alu_ctl == OP_CMP) ? in_b : sub_ext[M:0];
                alu_c   = sub_ext[WIDTH];
                alu_v   = (in_a[M] != in_b[M]) && (sub_ext[M] != in_a[M]);
            end
            OP_AND: begin
                flag_r  = in_a & in_b;
                alu_out = in_a & in_b;
            end
            OP_OR: begin
                flag_r  = in_a | in_b;
                alu_out = in_a | in_b;
            end
            OP_XOR: begin
                flag_r  = in_a ^ in_b;
                alu_out = in_a ^ in_b;
            end
            OP_MOV, OP_SLL, OP_SRL, OP_SRA: begin
                // shifts only reach this path with a zero amount
                flag_r  = in_a;
                alu_out = in_a;
            end
            default: alu_keep = 1'b1;
        endcase
        alu_szcv = alu_keep ? szcv : {flag_r[M], (flag_r == '0), alu_c, alu_v};
    end

    always_comb begin
        step_r = work;
        step_c = 1'b0;
        case (sh_op)
            OP_SLL: begin
                step_r = {work[M-1:0], 1'b0};
                step_c = work[M];
            end
            OP_SRL: begin
                step_r = {1'b0, work[M:1]};
                step_c = work[0];
            end
            OP_SRA: begin
                step_r = {work[M], work[M:1]};
                step_c = work[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt     = state;
        out_nxt       = out;
        szcv_nxt      = szcv;
        out_valid_nxt = out_valid;
        work_nxt      = work;
        cnt_nxt       = cnt;
        sh_op_nxt     = sh_op;
        case (state)
            IDLE, HOLD: begin
                if (accept) begin
                    if (is_shift && (amt != '0)) begin
                        state_nxt     = SHIFT;
                        out_valid_nxt = 1'b0;
                        work_nxt      = in_a;
                        cnt_nxt       = amt;
                        sh_op_nxt     = alu_ctl;
                    end else begin
                        state_nxt     = HOLD;
                        out_valid_nxt = 1'b1;
                        out_nxt       = alu_out;
                        szcv_nxt      = alu_szcv;
                    end
                end else if ((state == HOLD) && out_ready) begin
                    state_nxt     = IDLE;
                    out_valid_nxt = 1'b0;
                end
            end
            SHIFT: begin
                work_nxt = step_r;
                cnt_nxt  = cnt - 1'b1;
                if (cnt == SHW'(1)) begin
                    state_nxt     = HOLD;
                    out_valid_nxt = 1'b1;
                    out_nxt       = step_r;
                    szcv_nxt      = {step_r[M], (step_r == '0), step_c, 1'b0};
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out       <= '0;
            out_valid <= 1'b0;
            szcv      <= 4'b0000;
            work      <= '0;
            cnt       <= '0;
            sh_op     <= '0;
        end else begin
            state     <= state_nxt;
            out       <= out_nxt;
            out_valid <= out_valid_nxt;
            szcv      <= szcv_nxt;
            work      <= work_nxt;
            cnt       <= cnt_nxt;
            sh_op     <= sh_op_nxt;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed literal cases plus randomized traffic compared every
// cycle against an arithmetic reference model of the ALU and its handshake timing.
module tb_alu_seq;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctl;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out;
    logic [3:0]  szcv;

    int n_tests = 0;
    int n_fail  = 0;
    bit rand_ordy = 0;

    alu_seq #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctl   (alu_ctl),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .szcv      (szcv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result {out, szcv} computed from integer arithmetic.
    function automatic logic [19:0] model_op(input logic [3:0] op, input logic [15:0] a,
                                             input logic [15:0] b, input logic [3:0] f);
        int ua, ub, sa, sb, k, ur, sr, amt;
        logic [15:0] r;
        logic c, v;
        ua = int'(a); ub = int'(b);
        sa = int'($signed(a)); sb = int'($signed(b));
        amt = int'(b[3:0]);
        r = '0; c = 1'b0; v = 1'b0;
        case (op)
            4'd0, 4'd7: begin
                k  = (op == 4'd7) ? int'(f[1]) : 0;
                ur = ua + ub + k;
                sr = sa + sb + k;
                r  = ur[15:0];
                c  = (ur > 65535);
                v  = (sr > 32767) || (sr < -32768);
            end
            4'd1, 4'd5, 4'd8: begin
                k  = (op == 4'd8) ? int'(f[1]) : 0;
                ur = ua - ub - k;
                sr = sa - sb - k;
                r  = ur[15:0];
                c  = (ur < 0);
                v  = (sr > 32767) || (sr < -32768);
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd6: r = a;
            4'd9: begin
                r = a << amt;
                c = (amt == 0) ? 1'b0 : a[16 - amt];
            end
            4'd10: begin
                r = a >> amt;
                c = (amt == 0) ? 1'b0 : a[amt - 1];
            end
            4'd11: begin
                r = $signed(a) >>> amt;
                c = (amt == 0) ? 1'b0 : a[amt - 1];
            end
            default: return {16'h0000, f};
        endcase
        if (op == 4'd5) return {b, r[15], (r == 16'h0), c, v};
        return {r, r[15], (r == 16'h0), c, v};
    endfunction

    logic [15:0] m_out;
    logic [3:0]  m_szcv;
    logic        m_valid;
    int          m_wait;
    logic [19:0] m_pend;
    logic [19:0] m_calc;
    logic        m_ready;

    assign m_calc  = model_op(alu_ctl, in_a, in_b, m_szcv);
    assign m_ready = (m_wait == 0) && (!m_valid || out_ready);

    // Model timing: non-shift results appear after the accept edge, shifts after amt more edges.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_out   <= '0;
            m_szcv  <= '0;
            m_valid <= 1'b0;
            m_wait  <= 0;
            m_pend  <= '0;
        end else if (m_wait != 0) begin
            m_wait <= m_wait - 1;
            if (m_wait == 1) begin
                m_valid <= 1'b1;
                m_out   <= m_pend[19:4];
                m_szcv  <= m_pend[3:0];
            end
        end else if (in_valid && m_ready) begin
            if ((alu_ctl >= 4'd9) && (alu_ctl <= 4'd11) && (in_b[3:0] != 4'd0)) begin
                m_wait  <= int'(in_b[3:0]);
                m_valid <= 1'b0;
                m_pend  <= m_calc;
            end else begin
                m_valid <= 1'b1;
                m_out   <= m_calc[19:4];
                m_szcv  <= m_calc[3:0];
            end
        end else if (m_valid && out_ready) begin
            m_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready", 32'(in_ready), 32'(m_ready));
            check("out_valid", 32'(out_valid), 32'(m_valid));
            check("out", 32'(out), 32'(m_out));
            check("szcv", 32'(szcv), 32'(m_szcv));
        end
    end

    always @(posedge clk) begin
        if (rand_ordy) begin
            #1 out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        int  guard;
        bit  done;
        guard = 0;
        done  = 1'b0;
        alu_ctl  = op;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk);
            #1;
            guard++;
            if (!done && guard > 200) begin
                check("accept_timeout", 32'(guard), 32'(0));
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
        alu_ctl  = 4'($urandom);
        in_a     = 16'($urandom);
        in_b     = 16'($urandom);
    endtask

    task automatic run_op(input string name, input logic [3:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] exp_out,
                          input logic [3:0] exp_szcv, input int exp_lat);
        int lat;
        out_ready = 1'b1;
        issue(op, a, b);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_lat"}, 32'(lat), 32'(exp_lat));
        check({name, "_out"}, 32'(out), 32'(exp_out));
        check({name, "_szcv"}, 32'(szcv), 32'(exp_szcv));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        alu_ctl   = 4'd0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_out", 32'(out), 32'(0));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_szcv", 32'(szcv), 32'(0));
        check("rst_in_ready", 32'(in_ready), 32'(1));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("add_ovf", 4'd0, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001, 1);
        run_op("sub_brw", 4'd1, 16'h0001, 16'h0002, 16'hFFFF, 4'b1010, 1);
        run_op("cmp",     4'd5, 16'h0001, 16'h0002, 16'h0002, 4'b1010, 1);
        run_op("add_cz",  4'd0, 16'hFFFF, 16'h0001, 16'h0000, 4'b0110, 1);
        run_op("adc",     4'd7, 16'h0000, 16'h0000, 16'h0001, 4'b0000, 1);
        run_op("sra4",    4'd11, 16'h8001, 16'h0004, 16'hF800, 4'b1000, 5);
        run_op("sll0",    4'd9, 16'h1234, 16'h0010, 16'h1234, 4'b0000, 1);
        run_op("rsvd",    4'd13, 16'h1111, 16'h2222, 16'h0000, 4'b0000, 1);

        // Stall in HOLD, then accept the next op in the same cycle the result is taken.
        out_ready = 1'b0;
        issue(4'd0, 16'h0003, 16'h0004);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_out", 32'(out), 32'h0007);
            check("stall_valid", 32'(out_valid), 32'(1));
            check("stall_in_ready", 32'(in_ready), 32'(0));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        issue(4'd4, 16'h00FF, 16'h0F0F);
        @(negedge clk);
        check("b2b_valid", 32'(out_valid), 32'(1));
        check("b2b_out", 32'(out), 32'h0FF0);
        @(posedge clk);
        #1;

        // Reset in the middle of a shift.
        run_op("pre_rst", 4'd1, 16'h0001, 16'h0002, 16'hFFFF, 4'b1010, 1);
        issue(4'd10, 16'hF0F0, 16'h0004);
        @(posedge clk);
        #1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_out", 32'(out), 32'(0));
        check("abort_valid", 32'(out_valid), 32'(0));
        check("abort_szcv", 32'(szcv), 32'(0));
        check("abort_in_ready", 32'(in_ready), 32'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        rand_ordy = 1'b1;
        for (int n = 0; n < 400; n++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            issue(4'($urandom_range(0, 15)), pick(), pick());
        end
        rand_ordy = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (30) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
